// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared constants, debounce state encoding and counter-width
//                helper for the keypad entry block.
//  Contents    : KEY_* code constants, deb_state_t, deb_cnt_w()
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Bit position of the "key present" flag in the scanner code.
    localparam int KEY_PRESENT_BIT = 4;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_A         = 4'hA;
    localparam logic [3:0] KEY_D         = 4'hD;
    localparam logic [3:0] KEY_E         = 4'hE;
    localparam logic [3:0] KEY_F         = 4'hF;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } deb_state_t;

    // The debounce counter only ever holds 1..DEB_CYC-1.
    function automatic int deb_cnt_w(input int deb);
        return (deb <= 2) ? 1 : $clog2(deb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Turns the held 5-bit scanner code into exactly one press
//                event per physical press. A press or release is accepted
//                only after the normalised sample has been stable for
//                DEB_CYC clocks.
//  Ports       : clk, rst (async, active-high)
//                keypad_in [4:0]  {present, code}
//                key_valid        one-cycle pulse per accepted press
//                key_code  [3:0]  code of last accepted press (held)
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEB_CYC = 201400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] keypad_in,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int            CW         = deb_cnt_w(DEB_CYC);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [CW-1:0] c_cnt_last = CW'(DEB_CYC - 1);

    deb_state_t    r_state;
    logic [4:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [4:0]    w_sample;

    // Any code without the present bit counts as "released".
    assign w_sample = keypad_in[KEY_PRESENT_BIT] ? keypad_in : 5'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cand    <= 5'b0;
            r_cnt     <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            key_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sample != 5'b0) begin
                        r_state <= PRESS_WAIT;
                        r_cand  <= w_sample;
                        r_cnt   <= c_cnt_one;
                    end
                end
                PRESS_WAIT: begin
                    if (w_sample == 5'b0) begin
                        r_state <= IDLE;
                    end else if (w_sample != r_cand) begin
                        // A different key restarts the window on the new code.
                        r_cand <= w_sample;
                        r_cnt  <= c_cnt_one;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state   <= HELD;
                        key_valid <= 1'b1;
                        key_code  <= r_cand[3:0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    // Counter is frozen here, so a long hold never wraps or repeats.
                    if (w_sample != r_cand) begin
                        r_state <= REL_WAIT;
                        r_cnt   <= c_cnt_one;
                    end
                end
                REL_WAIT: begin
                    if (w_sample == r_cand) begin
                        r_state <= HELD;
                    end else if (r_cnt == c_cnt_last) begin
                        // A new key still down here is picked up from IDLE
                        // with a full press window.
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_entry
//  Description : Debounces scanner codes and assembles decimal keys into an
//                NDIG-digit BCD entry. E commits a non-empty entry, F clears
//                it, A-D are forwarded as command pulses.
//  Ports       : clk, rst (async, active-high)
//                keypad_in   [4:0]        scanner {present, code}
//                key_valid / key_code     accepted press event / code
//                digits      [4*NDIG-1:0] live buffer, newest digit in [3:0]
//                digit_cnt   [3:0]        digits held, 0..NDIG
//                entry_done / entry_value commit pulse / committed buffer
//                cmd_valid  / cmd_code    A-D pulse / command index 0..3
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DEB_CYC = 201400,
    parameter int NDIG    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          keypad_in,
    output logic                key_valid,
    output logic [3:0]          key_code,
    output logic [4*NDIG-1:0]   digits,
    output logic [3:0]          digit_cnt,
    output logic                entry_done,
    output logic [4*NDIG-1:0]   entry_value,
    output logic                cmd_valid,
    output logic [1:0]          cmd_code
);

    localparam logic [3:0] c_ndig = 4'(NDIG);

    logic [4*NDIG-1:0] w_shifted;

    key_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .keypad_in (keypad_in),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    // Buffer with the new digit shifted in at the low end.
    generate
        if (NDIG == 1) begin : g_shift_single
            assign w_shifted = key_code;
        end else begin : g_shift_multi
            assign w_shifted = {digits[4*NDIG-5:0], key_code};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            digit_cnt   <= 4'd0;
            entry_done  <= 1'b0;
            entry_value <= '0;
            cmd_valid   <= 1'b0;
            cmd_code    <= 2'd0;
        end else begin
            entry_done <= 1'b0;
            cmd_valid  <= 1'b0;
            if (key_valid) begin
                if (key_code <= KEY_DIGIT_MAX) begin
                    // A full buffer silently drops further digits.
                    if (digit_cnt < c_ndig) begin
                        digits    <= w_shifted;
                        digit_cnt <= digit_cnt + 4'd1;
                    end
                end else if (key_code == KEY_E) begin
                    // Committing an empty buffer is a no-op; the last value stays.
                    if (digit_cnt != 4'd0) begin
                        entry_value <= digits;
                        entry_done  <= 1'b1;
                        digits      <= '0;
                        digit_cnt   <= 4'd0;
                    end
                end else if (key_code == KEY_F) begin
                    digits    <= '0;
                    digit_cnt <= 4'd0;
                end else if (key_code <= KEY_D) begin
                    // A..D map to 0..3; the low two bits minus A's low bits do it.
                    cmd_code  <= key_code[1:0] - KEY_A[1:0];
                    cmd_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_entry
//  Description : Self-checking bench for keypad_entry (DEB_CYC=8, NDIG=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry;

    localparam int DEB  = 8;
    localparam int ND   = 4;

    logic          clk;
    logic          rst;
    logic [4:0]    keypad_in;
    logic          key_valid;
    logic [3:0]    key_code;
    logic [15:0]   digits;
    logic [3:0]    digit_cnt;
    logic          entry_done;
    logic [15:0]   entry_value;
    logic          cmd_valid;
    logic [1:0]    cmd_code;

    keypad_entry #(
        .DEB_CYC (DEB),
        .NDIG    (ND)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .keypad_in   (keypad_in),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .digits      (digits),
        .digit_cnt   (digit_cnt),
        .entry_done  (entry_done),
        .entry_value (entry_value),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  key;
        logic [15:0] dig;
        logic [3:0]  cnt;
        logic        done;
        logic [15:0] val;
        logic        cmdv;
        logic [1:0]  cmd;
    } vec_t;

    vec_t tbl [14];
    vec_t exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one press, measure key_valid latency, then release.
    task automatic press(input logic [4:0] k, input int hold, input int rel);
        int lat;
        lat = -1;
        @(negedge clk);
        keypad_in = k;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (key_valid && lat < 0) lat = i;
        end
        keypad_in = 5'b0;
        repeat (rel) @(negedge clk);
        chk("press_latency", lat, DEB);
    endtask

    // Scoreboard: pop an expectation on key_valid, check the buffer one cycle later.
    initial begin : monitor
        vec_t e;
        logic pending;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 1'b0;
            end else if (key_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_key_valid: got code 0x%0h expected no event at %0t",
                             key_code, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("key_code", key_code, e.key);
                    pending = 1'b1;
                end
            end else if (pending) begin
                pending = 1'b0;
                chk("digits", digits, e.dig);
                chk("digit_cnt", digit_cnt, e.cnt);
                chk("entry_done", entry_done, e.done);
                chk("entry_value", entry_value, e.val);
                chk("cmd_valid", cmd_valid, e.cmdv);
                chk("cmd_code", cmd_code, e.cmd);
            end else if (entry_done || cmd_valid) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_pulse: got done=%0b cmd=%0b expected 0 at %0t",
                         entry_done, cmd_valid, $time);
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        vec_t r;

        //          key    digits    cnt   done  value     cmdv  cmd
        tbl[0]  = '{4'hF, 16'h0000, 4'd0, 1'b0, 16'h0000, 1'b0, 2'd0};
        tbl[1]  = '{4'h1, 16'h0001, 4'd1, 1'b0, 16'h0000, 1'b0, 2'd0};
        tbl[2]  = '{4'h2, 16'h0012, 4'd2, 1'b0, 16'h0000, 1'b0, 2'd0};
        tbl[3]  = '{4'h3, 16'h0123, 4'd3, 1'b0, 16'h0000, 1'b0, 2'd0};
        tbl[4]  = '{4'h4, 16'h1234, 4'd4, 1'b0, 16'h0000, 1'b0, 2'd0};
        tbl[5]  = '{4'h5, 16'h1234, 4'd4, 1'b0, 16'h0000, 1'b0, 2'd0};
        tbl[6]  = '{4'hE, 16'h0000, 4'd0, 1'b1, 16'h1234, 1'b0, 2'd0};
        tbl[7]  = '{4'hE, 16'h0000, 4'd0, 1'b0, 16'h1234, 1'b0, 2'd0};
        tbl[8]  = '{4'h7, 16'h0007, 4'd1, 1'b0, 16'h1234, 1'b0, 2'd0};
        tbl[9]  = '{4'hF, 16'h0000, 4'd0, 1'b0, 16'h1234, 1'b0, 2'd0};
        tbl[10] = '{4'h8, 16'h0008, 4'd1, 1'b0, 16'h1234, 1'b0, 2'd0};
        tbl[11] = '{4'hC, 16'h0008, 4'd1, 1'b0, 16'h1234, 1'b1, 2'd2};
        tbl[12] = '{4'hA, 16'h0008, 4'd1, 1'b0, 16'h1234, 1'b1, 2'd0};
        tbl[13] = '{4'hD, 16'h0008, 4'd1, 1'b0, 16'h1234, 1'b1, 2'd3};

        rst       = 1'b1;
        keypad_in = 5'b0;
        repeat (3) @(negedge clk);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_digits", digits, 0);
        chk("rst_digit_cnt", digit_cnt, 0);
        chk("rst_entry_value", entry_value, 0);
        rst = 1'b0;

        // Single long hold: one event only.
        exp_q.push_back('{4'h5, 16'h0005, 4'd1, 1'b0, 16'h0000, 1'b0, 2'd0});
        press(5'b10101, 20, 20);

        // Bounce never lasts long enough to be accepted.
        for (int b = 0; b < 5; b++) begin
            keypad_in = 5'b10011;
            repeat (3) @(negedge clk);
            keypad_in = 5'b00000;
            repeat (3) @(negedge clk);
        end
        exp_q.push_back('{4'h3, 16'h0053, 4'd2, 1'b0, 16'h0000, 1'b0, 2'd0});
        press(5'b10011, 10, 12);

        // Entry, overflow, commit, empty commit, clear and commands.
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(tbl[i]);
            press({1'b1, tbl[i].key}, 12, 12);
        end

        // Reset in the middle of a held key.
        exp_q.push_back('{4'h9, 16'h0089, 4'd2, 1'b0, 16'h1234, 1'b0, 2'd3});
        @(negedge clk);
        keypad_in = 5'b11001;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_key_valid", key_valid, 0);
        chk("midrst_key_code", key_code, 0);
        chk("midrst_digits", digits, 0);
        chk("midrst_digit_cnt", digit_cnt, 0);
        chk("midrst_entry_value", entry_value, 0);
        chk("midrst_cmd_code", cmd_code, 0);
        exp_q.push_back('{4'h9, 16'h0009, 4'd1, 1'b0, 16'h0000, 1'b0, 2'd0});
        rst = 1'b0;
        lat = -1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (key_valid && lat < 0) lat = i;
        end
        chk("post_rst_latency", lat, DEB);
        keypad_in = 5'b0;
        repeat (14) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
